// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the backing-memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR
    } arb_state_t;

    typedef enum logic [1:0] {
        G_NONE,
        G_I,
        G_DRD,
        G_DWR
    } grant_t;

    localparam int unsigned BYTES_PER_WORD = 4;

    // Clears the byte-in-word and word-in-burst offset bits of a line address.
    function automatic logic [63:0] burst_base(input logic [63:0] addr,
                                               input int unsigned burst_len);
        logic [63:0] mask;
        mask = 64'(burst_len * BYTES_PER_WORD) - 64'd1;
        return addr & ~mask;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side (three cache clients) and memory-side bundles of the arbiter.
interface mem_arb_core_if #(
    parameter int unsigned ADDR_WIDTH = 26,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  i_rd_req;
    logic [ADDR_WIDTH-1:0] i_rd_addr;
    logic                  i_rd_valid;
    logic [DATA_WIDTH-1:0] i_rd_data;
    logic                  i_rd_done;
    logic                  d_rd_req;
    logic [ADDR_WIDTH-1:0] d_rd_addr;
    logic                  d_rd_valid;
    logic [DATA_WIDTH-1:0] d_rd_data;
    logic                  d_rd_done;
    logic                  d_wr_req;
    logic [ADDR_WIDTH-1:0] d_wr_addr;
    logic [DATA_WIDTH-1:0] d_wr_data;
    logic                  d_wr_ready;
    logic                  d_wr_done;

    modport master (
        output i_rd_req, i_rd_addr, d_rd_req, d_rd_addr,
               d_wr_req, d_wr_addr, d_wr_data,
        input  i_rd_valid, i_rd_data, i_rd_done,
               d_rd_valid, d_rd_data, d_rd_done,
               d_wr_ready, d_wr_done
    );

    modport slave (
        input  i_rd_req, i_rd_addr, d_rd_req, d_rd_addr,
               d_wr_req, d_wr_addr, d_wr_data,
        output i_rd_valid, i_rd_data, i_rd_done,
               d_rd_valid, d_rd_data, d_rd_done,
               d_wr_ready, d_wr_done
    );
endinterface

interface mem_arb_mem_if #(
    parameter int unsigned ADDR_WIDTH = 26,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  mem_rd_req;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic                  mem_rd_ack;
    logic                  mem_rd_valid;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  mem_wr_req;
    logic [ADDR_WIDTH-1:0] mem_wr_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic                  mem_wr_ready;

    modport master (
        output mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_data,
        input  mem_rd_ack, mem_rd_valid, mem_rd_data, mem_wr_ready
    );

    modport slave (
        input  mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_data,
        output mem_rd_ack, mem_rd_valid, mem_rd_data, mem_wr_ready
    );
endinterface

// File: rtl/mem_arb_priority.sv
// Winner select: write-back > D-fill > I-fill, unless the I-side has starved.
module mem_arb_priority
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic             i_ireq,
    input  logic             i_drd_req,
    input  logic             i_dwr_req,
    input  logic [CNT_W-1:0] i_starve_cnt,
    output grant_t           o_grant
);

    always_comb begin
        o_grant = G_NONE;
        if (i_ireq && (i_starve_cnt == CNT_W'(STARVE_LIMIT))) begin
            o_grant = G_I;
        end else if (i_dwr_req) begin
            o_grant = G_DWR;
        end else if (i_drd_req) begin
            o_grant = G_DRD;
        end else if (i_ireq) begin
            o_grant = G_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-fill, D-fill and D-write-back bursts onto one memory port.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 26,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned BURST_LEN    = 4,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_arb_core_if.slave  core,
    mem_arb_mem_if.master  mem
);

    localparam int unsigned BEAT_W = $clog2(BURST_LEN);
    localparam int unsigned CNT_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    arb_state_t            r_state;
    arb_state_t            w_next_state;
    grant_t                r_grant;
    grant_t                w_win;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [ADDR_WIDTH-1:0] w_beat_addr;
    logic [BEAT_W-1:0]     r_beat;
    logic [CNT_W-1:0]      r_starve_cnt;
    logic                  w_last_beat;
    logic [DATA_WIDTH-1:0] w_rd_data;

    mem_arb_priority #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_priority (
        .i_ireq       (core.i_rd_req),
        .i_drd_req    (core.d_rd_req),
        .i_dwr_req    (core.d_wr_req),
        .i_starve_cnt (r_starve_cnt),
        .o_grant      (w_win)
    );

    always_comb begin
        case (w_win)
            G_I:     w_sel_addr = core.i_rd_addr;
            G_DRD:   w_sel_addr = core.d_rd_addr;
            G_DWR:   w_sel_addr = core.d_wr_addr;
            default: w_sel_addr = '0;
        endcase
    end

    // Base is line aligned, so the beat offset never carries out of the line.
    assign w_beat_addr = r_base + ADDR_WIDTH'({r_beat, 2'b00});
    assign w_last_beat = (r_beat == LAST_BEAT);
    assign w_rd_data   = mem.mem_rd_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grant      <= G_NONE;
            r_base       <= '0;
            r_beat       <= '0;
            r_starve_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_grant <= w_win;
                    r_beat  <= '0;
                    if (w_win != G_NONE) begin
                        r_base <= ADDR_WIDTH'(burst_base(64'(w_sel_addr), BURST_LEN));
                    end
                    if (w_win == G_I) begin
                        r_starve_cnt <= '0;
                    end else if ((w_win == G_DRD || w_win == G_DWR) && core.i_rd_req &&
                                 (r_starve_cnt != CNT_W'(STARVE_LIMIT))) begin
                        r_starve_cnt <= r_starve_cnt + 1'b1;
                    end
                end
                RD_DATA: if (mem.mem_rd_valid) r_beat <= r_beat + 1'b1;
                WR:      if (mem.mem_wr_ready) r_beat <= r_beat + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next_state     = r_state;
        core.i_rd_valid  = 1'b0;
        core.i_rd_data   = '0;
        core.i_rd_done   = 1'b0;
        core.d_rd_valid  = 1'b0;
        core.d_rd_data   = '0;
        core.d_rd_done   = 1'b0;
        core.d_wr_ready  = 1'b0;
        core.d_wr_done   = 1'b0;
        mem.mem_rd_req   = 1'b0;
        mem.mem_rd_addr  = '0;
        mem.mem_wr_req   = 1'b0;
        mem.mem_wr_addr  = '0;
        mem.mem_wr_data  = '0;
        case (r_state)
            IDLE: begin
                case (w_win)
                    G_I, G_DRD: w_next_state = RD_REQ;
                    G_DWR:      w_next_state = WR;
                    default:    w_next_state = IDLE;
                endcase
            end
            RD_REQ: begin
                mem.mem_rd_req  = 1'b1;
                mem.mem_rd_addr = r_base;
                if (mem.mem_rd_ack) w_next_state = RD_DATA;
            end
            RD_DATA: begin
                if (r_grant == G_I) begin
                    core.i_rd_valid = mem.mem_rd_valid;
                    core.i_rd_data  = w_rd_data;
                    core.i_rd_done  = mem.mem_rd_valid && w_last_beat;
                end else begin
                    core.d_rd_valid = mem.mem_rd_valid;
                    core.d_rd_data  = w_rd_data;
                    core.d_rd_done  = mem.mem_rd_valid && w_last_beat;
                end
                if (mem.mem_rd_valid && w_last_beat) w_next_state = IDLE;
            end
            WR: begin
                mem.mem_wr_req  = 1'b1;
                mem.mem_wr_addr = w_beat_addr;
                mem.mem_wr_data = core.d_wr_data;
                core.d_wr_ready = mem.mem_wr_ready;
                core.d_wr_done  = mem.mem_wr_ready && w_last_beat;
                if (mem.mem_wr_ready && w_last_beat) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; the bench plays both caches and memory.
module tb_mem_arbiter;

    localparam int AW = 26;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    mem_arb_core_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) cif ();
    mem_arb_mem_if  #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mif ();

    mem_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .BURST_LEN    (4),
        .STARVE_LIMIT (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .core  (cif),
        .mem   (mif)
    );

    always #5 clk = ~clk;

    logic [155:0] outs;
    assign outs = {cif.i_rd_valid, cif.i_rd_data, cif.i_rd_done,
                   cif.d_rd_valid, cif.d_rd_data, cif.d_rd_done,
                   cif.d_wr_ready, cif.d_wr_done,
                   mif.mem_rd_req, mif.mem_rd_addr,
                   mif.mem_wr_req, mif.mem_wr_addr, mif.mem_wr_data};

    // Services one read burst starting at the first RD_REQ cycle; ends in the IDLE gap cycle.
    task automatic serve_read(input bit to_i, input logic [AW-1:0] exp_addr,
                              input logic [DW-1:0] seed, input int ack_delay,
                              input int gap_cycle, input bit nxt_i, input bit nxt_d,
                              input string name);
        int k;
        int c;
        logic ev;
        logic [DW-1:0] got;
        for (int d = 0; d <= ack_delay; d++) begin
            @(negedge clk);
            mif.mem_rd_ack   = (d == ack_delay);
            mif.mem_rd_valid = 1'b1;
            mif.mem_rd_data  = 32'hDEAD_BEEF;
            #1;
            checks++;
            if (mif.mem_rd_req !== 1'b1 || mif.mem_rd_addr !== exp_addr) begin
                errors++;
                $display("FAIL %s rd_req: req=%0b addr=%h, expected req=1 addr=%h",
                         name, mif.mem_rd_req, mif.mem_rd_addr, exp_addr);
            end
            checks++;
            if ({cif.i_rd_valid, cif.d_rd_valid} !== 2'b00) begin
                errors++;
                $display("FAIL %s valid_in_rd_req: i=%0b d=%0b, expected 0 0",
                         name, cif.i_rd_valid, cif.d_rd_valid);
            end
        end
        k = 0;
        c = 0;
        while (k < 4) begin
            @(negedge clk);
            mif.mem_rd_ack   = 1'b0;
            ev               = (c != gap_cycle);
            mif.mem_rd_valid = ev;
            mif.mem_rd_data  = seed + 32'(k);
            #1;
            checks++;
            if ({cif.i_rd_valid, cif.d_rd_valid, cif.i_rd_done, cif.d_rd_done} !==
                {ev && to_i, ev && !to_i, ev && to_i && k == 3, ev && !to_i && k == 3}) begin
                errors++;
                $display("FAIL %s beat%0d flags: iv=%0b dv=%0b idone=%0b ddone=%0b, expected iv=%0b dv=%0b idone=%0b ddone=%0b",
                         name, k, cif.i_rd_valid, cif.d_rd_valid, cif.i_rd_done, cif.d_rd_done,
                         ev && to_i, ev && !to_i, ev && to_i && k == 3, ev && !to_i && k == 3);
            end
            if (ev) begin
                got = to_i ? cif.i_rd_data : cif.d_rd_data;
                checks++;
                if (got !== seed + 32'(k)) begin
                    errors++;
                    $display("FAIL %s beat%0d data: got %h, expected %h", name, k, got, seed + 32'(k));
                end
                k++;
            end
            c++;
        end
        @(negedge clk);
        mif.mem_rd_valid = 1'b0;
        cif.i_rd_req     = nxt_i;
        cif.d_rd_req     = nxt_d;
        #1;
        checks++;
        if ({cif.i_rd_done, cif.d_rd_done, mif.mem_rd_req, mif.mem_wr_req} !== 4'b0000) begin
            errors++;
            $display("FAIL %s idle_gap: idone=%0b ddone=%0b rd_req=%0b wr_req=%0b, expected all 0",
                     name, cif.i_rd_done, cif.d_rd_done, mif.mem_rd_req, mif.mem_wr_req);
        end
    endtask

    // Services one write burst starting at the first WR cycle; ends in the IDLE gap cycle.
    task automatic serve_write(input logic [AW-1:0] base, input logic [15:0] pat, input int n,
                               input bit nxt_w, input bit nxt_d, input bit nxt_i,
                               input string name);
        int acc;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        acc = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            mif.mem_wr_ready = pat[c];
            ed               = 32'hC0DE_0000 + 32'(c);
            cif.d_wr_data    = ed;
            #1;
            ea = base + AW'(acc * 4);
            checks++;
            if (mif.mem_wr_req !== 1'b1 || mif.mem_wr_addr !== ea || mif.mem_wr_data !== ed) begin
                errors++;
                $display("FAIL %s cyc%0d wr_beat: req=%0b addr=%h data=%h, expected req=1 addr=%h data=%h",
                         name, c, mif.mem_wr_req, mif.mem_wr_addr, mif.mem_wr_data, ea, ed);
            end
            checks++;
            if (cif.d_wr_ready !== pat[c] || cif.d_wr_done !== (pat[c] && acc == 3)) begin
                errors++;
                $display("FAIL %s cyc%0d wr_hs: ready=%0b done=%0b, expected ready=%0b done=%0b",
                         name, c, cif.d_wr_ready, cif.d_wr_done, pat[c], pat[c] && acc == 3);
            end
            if (pat[c]) acc++;
        end
        @(negedge clk);
        mif.mem_wr_ready = 1'b0;
        cif.d_wr_req     = nxt_w;
        cif.d_rd_req     = nxt_d;
        cif.i_rd_req     = nxt_i;
        #1;
        checks++;
        if ({cif.d_wr_done, mif.mem_wr_req, mif.mem_rd_req} !== 3'b000) begin
            errors++;
            $display("FAIL %s idle_gap: done=%0b wr_req=%0b rd_req=%0b, expected all 0",
                     name, cif.d_wr_done, mif.mem_wr_req, mif.mem_rd_req);
        end
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        mif.mem_rd_valid = 1'b1;
        mif.mem_rd_ack   = 1'b1;
        mif.mem_wr_ready = 1'b1;
        mif.mem_rd_data  = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, expected 0", outs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL idle_ignores_mem: got %h, expected 0", outs);
        end
        @(negedge clk);
        mif.mem_rd_valid = 1'b0;
        mif.mem_rd_ack   = 1'b0;
        mif.mem_wr_ready = 1'b0;
        mif.mem_rd_data  = '0;
    endtask

    task automatic test_i_read();
        @(negedge clk);
        cif.i_rd_req  = 1'b1;
        cif.i_rd_addr = 26'h000104;
        #1;
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL i_read_idle: got %h, expected 0", outs);
        end
        serve_read(1'b1, 26'h000100, 32'hA000_0000, 1, 2, 1'b0, 1'b0, "i_read");
    endtask

    task automatic test_priority();
        @(negedge clk);
        cif.d_wr_req  = 1'b1;
        cif.d_wr_addr = 26'h000204;
        cif.d_rd_req  = 1'b1;
        cif.d_rd_addr = 26'h00030C;
        cif.i_rd_req  = 1'b1;
        cif.i_rd_addr = 26'h00041C;
        serve_write(26'h000200, 16'h000F, 4, 1'b0, 1'b1, 1'b1, "prio_wr");
        serve_read(1'b0, 26'h000300, 32'hB000_0000, 0, -1, 1'b1, 1'b0, "prio_drd");
        serve_read(1'b1, 26'h000410, 32'hB100_0000, 0, -1, 1'b0, 1'b0, "prio_ird");
    endtask

    task automatic test_starvation();
        @(negedge clk);
        cif.d_rd_req  = 1'b1;
        cif.d_rd_addr = 26'h000500;
        cif.i_rd_req  = 1'b1;
        cif.i_rd_addr = 26'h000600;
        for (int r = 0; r < 4; r++) begin
            serve_read(1'b0, 26'h000500, 32'h5000_0000 + 32'(r * 16), 0, -1, 1'b1, 1'b1, "starve_d");
        end
        serve_read(1'b1, 26'h000600, 32'h6000_0000, 0, -1, 1'b1, 1'b1, "starve_i");
        // Counter cleared by the I grant, so D wins again even with I still waiting.
        serve_read(1'b0, 26'h000500, 32'h7000_0000, 0, -1, 1'b0, 1'b0, "starve_clr");
    endtask

    task automatic test_write_ready();
        @(negedge clk);
        cif.d_wr_req  = 1'b1;
        cif.d_wr_addr = 26'h000A4C;
        serve_write(26'h000A40, 16'h0059, 7, 1'b0, 1'b0, 1'b0, "wr_ready");
    endtask

    task automatic test_addr_wrap();
        @(negedge clk);
        cif.d_wr_req  = 1'b1;
        cif.d_wr_addr = 26'h3FFFFF8;
        serve_write(26'h3FFFFF0, 16'h000F, 4, 1'b0, 1'b0, 1'b0, "wr_top");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        cif.i_rd_req  = 1'b1;
        cif.i_rd_addr = 26'h000704;
        @(negedge clk);
        mif.mem_rd_ack = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            mif.mem_rd_ack   = 1'b0;
            mif.mem_rd_valid = 1'b1;
            mif.mem_rd_data  = 32'hE100_0000 + 32'(k);
            #1;
            checks++;
            if (cif.i_rd_valid !== 1'b1 || cif.i_rd_data !== 32'hE100_0000 + 32'(k)) begin
                errors++;
                $display("FAIL rst_mid beat%0d: valid=%0b data=%h, expected valid=1 data=%h",
                         k, cif.i_rd_valid, cif.i_rd_data, 32'hE100_0000 + 32'(k));
            end
        end
        @(negedge clk);
        rst_n           = 1'b0;
        mif.mem_rd_data = 32'hE100_0002;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %h, expected 0", outs);
        end
        serve_read(1'b1, 26'h000700, 32'hE000_0000, 0, -1, 1'b0, 1'b0, "rst_resume");
    endtask

    initial begin
        rst_n            = 1'b0;
        cif.i_rd_req     = 1'b0;
        cif.i_rd_addr    = '0;
        cif.d_rd_req     = 1'b0;
        cif.d_rd_addr    = '0;
        cif.d_wr_req     = 1'b0;
        cif.d_wr_addr    = '0;
        cif.d_wr_data    = '0;
        mif.mem_rd_ack   = 1'b0;
        mif.mem_rd_valid = 1'b0;
        mif.mem_rd_data  = '0;
        mif.mem_wr_ready = 1'b0;
        test_reset();
        test_i_read();
        test_priority();
        test_starvation();
        test_write_ready();
        test_addr_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
